kernel_bram_load_read_ctrl: RTL and testbench
=============================================

// Module: kernel_bram_load_read_ctrl
// PURPOSE
//  Sequencer for the 256x144 kernel BRAM used by Conv2d (port A write, port B read, 1-cycle read latency).
//  LOAD: accepts 3x3 kernels from a stream of KERNEL_WIDTH-bit weights, packs 9 weights per word, writes port A.
//  READ: walks port B addresses 0..N-1, one kernel per consumer request; tags each returned word with kernel_valid.
//  Sits between the DMA/AXI-stream weight loader and the conv MAC array; owns all BRAM enables and addresses.
// PARAMETERS
//  KERNEL_WIDTH  16   bits per weight; BRAM word = 9*KERNEL_WIDTH (144)
//  ADDR_WIDTH    8    BRAM address bits; max kernels = 2**ADDR_WIDTH (256)
// PORTS
//  clk               in   1        single clock; all state on rising edge
//  rst_n             in   1        asynchronous, active-low reset
//  cfg_num_kernels   in   9        kernels to load/read; legal 0..256; latched at load_start/rd_start
//  load_start        in   1        1-cycle pulse: begin LOAD (honoured only in IDLE)
//  rd_start          in   1        1-cycle pulse: begin READ (honoured only in IDLE)
//  s_axis_tdata      in   KW       one weight; weight 0 first -> bits [KW-1:0]
//  s_axis_tvalid     in   1        weight valid
//  s_axis_tready     out  1        1 only in LOAD
//  s_axis_tlast      in   1        end of kernel set (checked only with KERNEL_TLAST_CHECK_EN)
//  rd_req            in   1        consumer requests next kernel (READ only)
//  ena_kernel_BRAM   out  1        port A enable
//  wea_kernel_BRAM   out  1        port A write enable
//  kernel_BRAM_addra out  8        port A address
//  kernel_BRAM_dina  out  9*KW     packed kernel
//  enb_kernel_BRAM   out  1        port B enable
//  kernel_BRAM_addrb out  8        port B address
//  kernel_valid      out  1        BRAM doutb holds the requested kernel this cycle
//  kernel_idx        out  8        index of kernel presented with kernel_valid
//  load_done         out  1        1-cycle pulse, LOAD finished
//  rd_done           out  1        1-cycle pulse, READ finished
//  busy              out  1        state != IDLE
//  load_err          out  1        sticky stream-framing error (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. Mid-operation reset aborts; no partial write issued afterwards.
//  FSM: IDLE -> LOAD on load_start; IDLE -> READ on rd_start; both same cycle -> LOAD wins, rd_start dropped.
//   Starts outside IDLE ignored. cfg_num_kernels==0: done pulse the cycle after start, no BRAM access, stay IDLE.
//  LOAD: handshake = tvalid & tready. Weight counter 0..8 packs into word[w*KW +: KW].
//   9th handshake -> next cycle ena=wea=1 (one cycle), addra=kernel count, dina=packed word; kernel count++.
//   tready stays 1 through the write cycle: back-to-back kernels at full rate, no bubbles.
//   After write of kernel N-1: load_done pulse same cycle as that write; state -> IDLE (tready 0 next cycle).
//  READ: rd_req sampled at edge k -> cycle k+1: enb=1, addrb=rd_ptr, rd_ptr++ -> cycle k+2: kernel_valid=1,
//   kernel_idx=that addr. Latency rd_req -> kernel_valid = 2 cycles; rd_req every cycle -> valid every cycle.
//   After N reads issued further rd_req ignored; rd_done pulses with last kernel_valid; state -> IDLE.
//  Addresses never wrap within an operation (N<=256); counters cleared on each start.
//  enb/ena are 0 whenever no access is issued (power); wea never 1 outside LOAD.
// CONFIGURATION
//  KERNEL_TLAST_CHECK_EN defined: load_err set (sticky) if tlast=1 on any handshake except the last weight of
//   kernel N-1, or tlast=0 on that last weight; cleared by load_start. Loading continues regardless.
//  Not defined: s_axis_tlast ignored, load_err tied 0. Port list identical in both builds.
// TESTING
//  Load N=2, 18 weights 0x0001..0x0012 no gaps -> 2 writes addr 0,1; word0[15:0]=0x0001,[143:128]=0x0009; load_done 1x.
//  Load N=1 with tvalid toggling every other cycle -> single write of correct word after 9th handshake, no extra writes.
//  Read N=3, rd_req held high -> enb 3 cycles addr 0,1,2; kernel_valid 3 cycles starting 2 after first req; rd_done on 3rd.
//  load_start & rd_start same cycle -> LOAD entered, no port-B activity; rd_start during LOAD ignored; N=0 -> done next cycle.
//  rst_n low after 5 weights -> all outputs 0 at once; new load of N=1 writes only the fresh 9 weights to addr 0.
//  KERNEL_TLAST_CHECK_EN: tlast on weight 4 of N=1 -> load_err=1 held until next load_start; undefined build -> stays 0.

Source files
------------

// File: rtl/kernel_bram_load_read_ctrl.sv
// ----------------------------------------------------------------------------
// kernel_bram_load_read_ctrl
//
// Sequencer for the 256x144 kernel BRAM used by Conv2d. Port A is written,
// port B is read, and the BRAM has a 1-cycle read latency.
//   LOAD : packs 9 KERNEL_WIDTH-bit weights from the stream into one BRAM word
//          (weight 0 in the low bits) and writes it through port A.
//   READ : issues one port B read per consumer request at addresses 0..N-1 and
//          marks the cycle in which doutb holds that kernel with kernel_valid.
//
// Optional build macro: KERNEL_TLAST_CHECK_EN
//   defined   : load_err is a sticky framing error. It is set when tlast does
//               not mark exactly the last weight of the last kernel, and it is
//               cleared by load_start. Loading continues regardless.
//   undefined : s_axis_tlast is ignored and load_err stays 0.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cfg_num_kernels     kernel count (0..2**ADDR_WIDTH), latched at a start
//   load_start/rd_start one-cycle start pulses, honoured only when idle
//   s_axis_*            weight stream (tready is high only while loading)
//   rd_req              consumer request for the next kernel
//   *_kernel_BRAM, kernel_BRAM_*   BRAM enables, addresses and write data
//   kernel_valid/idx    BRAM read data valid and the index of that kernel
//   load_done/rd_done   one-cycle completion pulses
//   busy                controller is not idle
//   load_err            sticky stream-framing error
// All outputs are registered.
// ----------------------------------------------------------------------------
module kernel_bram_load_read_ctrl #(
  parameter int KERNEL_WIDTH = 16,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_WIDTH:0]       cfg_num_kernels,
  input  logic                      load_start,
  input  logic                      rd_start,
  input  logic [KERNEL_WIDTH-1:0]   s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,
  input  logic                      rd_req,
  output logic                      ena_kernel_BRAM,
  output logic                      wea_kernel_BRAM,
  output logic [ADDR_WIDTH-1:0]     kernel_BRAM_addra,
  output logic [9*KERNEL_WIDTH-1:0] kernel_BRAM_dina,
  output logic                      enb_kernel_BRAM,
  output logic [ADDR_WIDTH-1:0]     kernel_BRAM_addrb,
  output logic                      kernel_valid,
  output logic [ADDR_WIDTH-1:0]     kernel_idx,
  output logic                      load_done,
  output logic                      rd_done,
  output logic                      busy,
  output logic                      load_err
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_READ = 2'd2} state_t;

  localparam logic [ADDR_WIDTH:0] CNT_ZERO  = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0] CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [3:0]          LAST_SLOT = 4'd8;

`ifdef KERNEL_TLAST_CHECK_EN
  localparam logic TLAST_CHECK = 1'b1;
`else
  localparam logic TLAST_CHECK = 1'b0;
`endif

  state_t                    state_r, state_nxt_s;
  logic [3:0]                wcnt_r;        // weight slot within current kernel
  logic [ADDR_WIDTH:0]       kcnt_r;        // kernels written so far
  logic [ADDR_WIDTH:0]       rd_ptr_r;      // reads issued so far
  logic [ADDR_WIDTH:0]       num_r;         // latched kernel count
  logic [8*KERNEL_WIDTH-1:0] pack_r;        // weights 0..7; weight 8 goes straight to dina

  logic                      tready_r, busy_r, ena_r, enb_r, kvalid_r;
  logic                      load_done_r, rd_done_r, load_err_r;
  logic [ADDR_WIDTH-1:0]     addra_r, addrb_r, kidx_r;
  logic [9*KERNEL_WIDTH-1:0] dina_r;

  logic start_load_s, start_rd_s, cfg_zero_s, hs_s, word_done_s, last_kernel_s;
  logic rd_issue_s, rd_return_s, rd_last_s, err_set_s;
  logic tready_nxt_s, busy_nxt_s, load_done_nxt_s, rd_done_nxt_s, load_err_nxt_s;

  // A simultaneous rd_start is dropped when load_start is also present.
  assign start_load_s  = (state_r == ST_IDLE) & load_start;
  assign start_rd_s    = (state_r == ST_IDLE) & rd_start & ~load_start;
  assign cfg_zero_s    = (cfg_num_kernels == CNT_ZERO);
  assign hs_s          = (state_r == ST_LOAD) & tready_r & s_axis_tvalid;
  assign word_done_s   = hs_s & (wcnt_r == LAST_SLOT);
  assign last_kernel_s = ((kcnt_r + CNT_ONE) == num_r);
  assign rd_issue_s    = (state_r == ST_READ) & rd_req & (rd_ptr_r != num_r);
  // The read issued last cycle returns now; it is the final one once all N are out.
  assign rd_return_s   = (state_r == ST_READ) & enb_r;
  assign rd_last_s     = rd_return_s & (rd_ptr_r == num_r);
  assign err_set_s     = TLAST_CHECK & hs_s &
                         (s_axis_tlast != ((wcnt_r == LAST_SLOT) & last_kernel_s));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; a zero-length operation never leaves IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_load_s && !cfg_zero_s) begin
          state_nxt_s = ST_LOAD;
        end else if (start_rd_s && !cfg_zero_s) begin
          state_nxt_s = ST_READ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (word_done_s && last_kernel_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_READ: begin
        if (rd_last_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_READ;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of the registered status outputs.
  always_comb begin
    tready_nxt_s    = (state_nxt_s == ST_LOAD);
    busy_nxt_s      = (state_nxt_s != ST_IDLE);
    load_done_nxt_s = (start_load_s & cfg_zero_s) | (word_done_s & last_kernel_s);
    rd_done_nxt_s   = (start_rd_s & cfg_zero_s) | rd_last_s;
    if (start_load_s) begin
      load_err_nxt_s = 1'b0;
    end else if (err_set_s) begin
      load_err_nxt_s = 1'b1;
    end else begin
      load_err_nxt_s = load_err_r;
    end
  end

  // Counters, packing register and registered BRAM/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_r      <= 4'd0;
      kcnt_r      <= CNT_ZERO;
      rd_ptr_r    <= CNT_ZERO;
      num_r       <= CNT_ZERO;
      pack_r      <= {(8*KERNEL_WIDTH){1'b0}};
      tready_r    <= 1'b0;
      busy_r      <= 1'b0;
      ena_r       <= 1'b0;
      enb_r       <= 1'b0;
      kvalid_r    <= 1'b0;
      load_done_r <= 1'b0;
      rd_done_r   <= 1'b0;
      load_err_r  <= 1'b0;
      addra_r     <= {ADDR_WIDTH{1'b0}};
      addrb_r     <= {ADDR_WIDTH{1'b0}};
      kidx_r      <= {ADDR_WIDTH{1'b0}};
      dina_r      <= {(9*KERNEL_WIDTH){1'b0}};
    end else begin
      tready_r    <= tready_nxt_s;
      busy_r      <= busy_nxt_s;
      ena_r       <= word_done_s;
      enb_r       <= rd_issue_s;
      kvalid_r    <= rd_return_s;
      load_done_r <= load_done_nxt_s;
      rd_done_r   <= rd_done_nxt_s;
      load_err_r  <= load_err_nxt_s;
      if (start_load_s) begin
        wcnt_r <= 4'd0;
        kcnt_r <= CNT_ZERO;
        num_r  <= cfg_num_kernels;
      end else if (start_rd_s) begin
        rd_ptr_r <= CNT_ZERO;
        num_r    <= cfg_num_kernels;
      end else if (word_done_s) begin
        wcnt_r  <= 4'd0;
        kcnt_r  <= kcnt_r + CNT_ONE;
        addra_r <= kcnt_r[ADDR_WIDTH-1:0];
        dina_r  <= {s_axis_tdata, pack_r};
      end else if (hs_s) begin
        wcnt_r <= wcnt_r + 4'd1;
        pack_r[wcnt_r[2:0]*KERNEL_WIDTH +: KERNEL_WIDTH] <= s_axis_tdata;
      end
      if (rd_issue_s) begin
        addrb_r  <= rd_ptr_r[ADDR_WIDTH-1:0];
        rd_ptr_r <= rd_ptr_r + CNT_ONE;
      end
      if (rd_return_s) begin
        kidx_r <= addrb_r;
      end
    end
  end

  assign s_axis_tready     = tready_r;
  assign busy              = busy_r;
  assign ena_kernel_BRAM   = ena_r;
  assign wea_kernel_BRAM   = ena_r;
  assign kernel_BRAM_addra = addra_r;
  assign kernel_BRAM_dina  = dina_r;
  assign enb_kernel_BRAM   = enb_r;
  assign kernel_BRAM_addrb = addrb_r;
  assign kernel_valid      = kvalid_r;
  assign kernel_idx        = kidx_r;
  assign load_done         = load_done_r;
  assign rd_done           = rd_done_r;
  assign load_err          = load_err_r;

endmodule

// File: tb/tb_kernel_bram_load_read_ctrl.sv
// ----------------------------------------------------------------------------
// Testbench for kernel_bram_load_read_ctrl. A transaction-level model (weight
// queue, kernel/read counters) predicts every output for the next cycle; one
// compare task checks the DUT on each falling edge. Directed scenarios add
// literal expectations on logged writes/reads; random operations follow.
// ----------------------------------------------------------------------------
module tb_kernel_bram_load_read_ctrl;
  localparam int KW = 16;
  localparam int WW = 9 * KW;
`ifdef KERNEL_TLAST_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [8:0]    cfg_num_kernels = 9'd0;
  logic          load_start = 1'b0, rd_start = 1'b0;
  logic [KW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0, rd_req = 1'b0;
  logic          ena_kernel_BRAM, wea_kernel_BRAM, enb_kernel_BRAM;
  logic [7:0]    kernel_BRAM_addra, kernel_BRAM_addrb, kernel_idx;
  logic [WW-1:0] kernel_BRAM_dina;
  logic          kernel_valid, load_done, rd_done, busy, load_err;

  kernel_bram_load_read_ctrl #(.KERNEL_WIDTH(KW), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_num_kernels(cfg_num_kernels),
    .load_start(load_start), .rd_start(rd_start),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .rd_req(rd_req),
    .ena_kernel_BRAM(ena_kernel_BRAM), .wea_kernel_BRAM(wea_kernel_BRAM),
    .kernel_BRAM_addra(kernel_BRAM_addra), .kernel_BRAM_dina(kernel_BRAM_dina),
    .enb_kernel_BRAM(enb_kernel_BRAM), .kernel_BRAM_addrb(kernel_BRAM_addrb),
    .kernel_valid(kernel_valid), .kernel_idx(kernel_idx),
    .load_done(load_done), .rd_done(rd_done), .busy(busy), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, cyc = 0;

  // Expected outputs for the current cycle.
  logic          e_tready, e_busy, e_ena, e_enb, e_kv, e_ld, e_rdd, e_err;
  logic [7:0]    e_addra, e_addrb, e_kidx;
  logic [WW-1:0] e_dina;
  // Model state.
  int            m_mode;      // 0 idle, 1 load, 2 read
  int            m_n, m_kw, m_issued, m_deliv;
  logic [KW-1:0] m_w[$];
  // Logs of observed DUT activity.
  int            wr_addr[$], enb_addr[$], enb_cyc[$], kv_idx[$], kv_cyc[$], rdd_cyc[$];
  logic [WW-1:0] wr_data[$];
  int            ld_cnt, rd_cnt;

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_logs();
    wr_addr.delete(); wr_data.delete(); enb_addr.delete(); enb_cyc.delete();
    kv_idx.delete(); kv_cyc.delete(); rdd_cyc.delete();
    ld_cnt = 0; rd_cnt = 0;
  endtask

  task automatic model_reset();
    e_tready = 1'b0; e_busy = 1'b0; e_ena = 1'b0; e_enb = 1'b0; e_kv = 1'b0;
    e_ld = 1'b0; e_rdd = 1'b0; e_err = 1'b0;
    e_addra = 8'd0; e_addrb = 8'd0; e_kidx = 8'd0; e_dina = '0;
    m_mode = 0; m_n = 0; m_kw = 0; m_issued = 0; m_deliv = 0; m_w.delete();
  endtask

  // Predict next-cycle outputs from the inputs currently driven.
  task automatic model_step();
    logic c_enb, c_tready, last;
    logic [7:0] c_addrb;
    c_enb = e_enb; c_addrb = e_addrb; c_tready = e_tready;
    e_ena = 1'b0; e_enb = 1'b0; e_kv = 1'b0; e_ld = 1'b0; e_rdd = 1'b0;
    if (m_mode == 0) begin
      if (load_start) begin
        e_err = 1'b0;
        if (cfg_num_kernels == 9'd0) e_ld = 1'b1;
        else begin m_mode = 1; m_n = int'(cfg_num_kernels); m_kw = 0; m_w.delete(); end
      end else if (rd_start) begin
        if (cfg_num_kernels == 9'd0) e_rdd = 1'b1;
        else begin m_mode = 2; m_n = int'(cfg_num_kernels); m_issued = 0; m_deliv = 0; end
      end
    end else if (m_mode == 1) begin
      if (s_axis_tvalid && c_tready) begin
        m_w.push_back(s_axis_tdata);
        last = (m_w.size() == 9) && (m_kw == m_n - 1);
        if (CHK && (s_axis_tlast != last)) e_err = 1'b1;
        if (m_w.size() == 9) begin
          e_ena = 1'b1;
          e_addra = 8'(m_kw);
          for (int i = 0; i < 9; i++) e_dina[i*KW +: KW] = m_w[i];
          m_kw++;
          m_w.delete();
          if (m_kw == m_n) begin e_ld = 1'b1; m_mode = 0; end
        end
      end
    end else begin
      if (c_enb) begin
        e_kv = 1'b1; e_kidx = c_addrb; m_deliv++;
        if (m_deliv == m_n) begin e_rdd = 1'b1; m_mode = 0; end
      end
      if (m_mode == 2 && rd_req && m_issued < m_n) begin
        e_enb = 1'b1; e_addrb = 8'(m_issued); m_issued++;
      end
    end
    e_tready = (m_mode == 1);
    e_busy   = (m_mode != 0);
  endtask

  // Compare every output against the model and log activity.
  task automatic compare_now();
    chk("tready", s_axis_tready, e_tready);
    chk("busy", busy, e_busy);
    chk("ena", ena_kernel_BRAM, e_ena);
    chk("wea", wea_kernel_BRAM, e_ena);
    chk("enb", enb_kernel_BRAM, e_enb);
    chk("kernel_valid", kernel_valid, e_kv);
    chk("load_done", load_done, e_ld);
    chk("rd_done", rd_done, e_rdd);
    chk("load_err", load_err, e_err);
    if (e_ena) begin
      chk("addra", kernel_BRAM_addra, e_addra);
      chk("dina", kernel_BRAM_dina, e_dina);
    end
    if (e_enb) chk("addrb", kernel_BRAM_addrb, e_addrb);
    if (e_kv) chk("kernel_idx", kernel_idx, e_kidx);
    if (ena_kernel_BRAM) begin wr_addr.push_back(int'(kernel_BRAM_addra)); wr_data.push_back(kernel_BRAM_dina); end
    if (enb_kernel_BRAM) begin enb_addr.push_back(int'(kernel_BRAM_addrb)); enb_cyc.push_back(cyc); end
    if (kernel_valid) begin kv_idx.push_back(int'(kernel_idx)); kv_cyc.push_back(cyc); end
    if (load_done) ld_cnt++;
    if (rd_done) begin rd_cnt++; rdd_cyc.push_back(cyc); end
  endtask

  // Drive one cycle of inputs (called at a falling edge), advance, compare.
  task automatic cyc_in(input logic ls, input logic rs, input logic [8:0] n, input logic tv,
                        input logic [KW-1:0] td, input logic tl, input logic rq);
    load_start = ls; rd_start = rs; cfg_num_kernels = n;
    s_axis_tvalid = tv; s_axis_tdata = td; s_axis_tlast = tl; rd_req = rq;
    model_step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    compare_now();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc_in(1'b0, 1'b0, 9'd0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    load_start = 1'b0; rd_start = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; rd_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_tready", s_axis_tready, 1'b0);   chk("rst_busy", busy, 1'b0);
    chk("rst_ena", ena_kernel_BRAM, 1'b0);    chk("rst_wea", wea_kernel_BRAM, 1'b0);
    chk("rst_addra", kernel_BRAM_addra, 8'd0); chk("rst_dina", kernel_BRAM_dina, '0);
    chk("rst_enb", enb_kernel_BRAM, 1'b0);    chk("rst_addrb", kernel_BRAM_addrb, 8'd0);
    chk("rst_kv", kernel_valid, 1'b0);        chk("rst_kidx", kernel_idx, 8'd0);
    chk("rst_load_done", load_done, 1'b0);    chk("rst_rd_done", rd_done, 1'b0);
    chk("rst_load_err", load_err, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    compare_now();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, dens, b;
    logic [KW-1:0] w;
    clear_logs();
    #2;
    do_reset();

    // N=2, 18 weights 1..18 back to back.
    clear_logs();
    cyc_in(1'b1, 1'b0, 9'd2, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 18; i++) cyc_in(1'b0, 1'b0, 9'd2, 1'b1, 16'(i + 1), i == 17, 1'b0);
    idle(3);
    chk("l2_writes", wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      chk("l2_addr0", wr_addr[0], 0);
      chk("l2_addr1", wr_addr[1], 1);
      chk("l2_w0_lo", wr_data[0][15:0], 16'h0001);
      chk("l2_w0_hi", wr_data[0][143:128], 16'h0009);
      chk("l2_w1_lo", wr_data[1][15:0], 16'h000A);
      chk("l2_w1_hi", wr_data[1][143:128], 16'h0012);
    end
    chk("l2_done_pulses", ld_cnt, 1);
    chk("l2_err", load_err, 1'b0);

    // N=1 with tvalid every other cycle.
    clear_logs();
    cyc_in(1'b1, 1'b0, 9'd1, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 18; i++)
      cyc_in(1'b0, 1'b0, 9'd1, (i % 2) == 0, ((i % 2) == 0) ? 16'(16'hA0 + i / 2) : 16'hFFFF, i == 16, 1'b0);
    idle(2);
    chk("gap_writes", wr_addr.size(), 1);
    if (wr_data.size() == 1) begin
      chk("gap_slot0", wr_data[0][15:0], 16'h00A0);
      chk("gap_slot4", wr_data[0][79:64], 16'h00A4);
      chk("gap_slot8", wr_data[0][143:128], 16'h00A8);
    end

    // Read N=3, rd_req held high.
    clear_logs();
    cyc_in(1'b0, 1'b1, 9'd3, 1'b0, 16'h0, 1'b0, 1'b0);
    c0 = cyc;
    for (int i = 0; i < 6; i++) cyc_in(1'b0, 1'b0, 9'd3, 1'b0, 16'h0, 1'b0, 1'b1);
    idle(2);
    chk("rd3_enb_count", enb_addr.size(), 3);
    chk("rd3_kv_count", kv_cyc.size(), 3);
    if (enb_addr.size() == 3 && kv_cyc.size() == 3 && rdd_cyc.size() == 1) begin
      chk("rd3_enb_first", enb_cyc[0], c0 + 1);
      chk("rd3_addr2", enb_addr[2], 2);
      chk("rd3_kv_first", kv_cyc[0], c0 + 2);
      chk("rd3_kv_last", kv_cyc[2], c0 + 4);
      chk("rd3_idx2", kv_idx[2], 2);
      chk("rd3_done_cyc", rdd_cyc[0], c0 + 4);
    end
    chk("rd3_done_count", rd_cnt, 1);

    // Simultaneous starts; rd_start during LOAD.
    clear_logs();
    cyc_in(1'b1, 1'b1, 9'd1, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) cyc_in(1'b0, i == 3, 9'd1, 1'b1, 16'(16'h50 + i), i == 8, 1'b1);
    idle(3);
    chk("both_enb", enb_addr.size(), 0);
    chk("both_writes", wr_addr.size(), 1);
    chk("both_rd_done", rd_cnt, 0);
    chk("both_ld_done", ld_cnt, 1);

    // N=0 starts.
    clear_logs();
    cyc_in(1'b1, 1'b0, 9'd0, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("n0_load_done", ld_cnt, 1);
    cyc_in(1'b0, 1'b1, 9'd0, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("n0_rd_done", rd_cnt, 1);
    idle(2);
    chk("n0_ld_single", ld_cnt, 1);
    chk("n0_no_access", wr_addr.size() + enb_addr.size(), 0);

    // Reset after 5 weights, then a fresh N=1 load.
    cyc_in(1'b1, 1'b0, 9'd1, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc_in(1'b0, 1'b0, 9'd1, 1'b1, 16'(16'h77 + i), 1'b0, 1'b0);
    do_reset();
    clear_logs();
    cyc_in(1'b1, 1'b0, 9'd1, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) cyc_in(1'b0, 1'b0, 9'd1, 1'b1, 16'(16'h100 + i), i == 8, 1'b0);
    idle(2);
    chk("rst_writes", wr_addr.size(), 1);
    if (wr_data.size() == 1) begin
      chk("rst_addr", wr_addr[0], 0);
      chk("rst_slot0", wr_data[0][15:0], 16'h0100);
      chk("rst_slot8", wr_data[0][143:128], 16'h0108);
    end

    // Misplaced tlast on weight 4.
    cyc_in(1'b1, 1'b0, 9'd1, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) cyc_in(1'b0, 1'b0, 9'd1, 1'b1, 16'(i), i == 4, 1'b0);
    idle(3);
    chk("tlast_err_held", load_err, CHK);
    cyc_in(1'b1, 1'b0, 9'd0, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("tlast_err_clear", load_err, 1'b0);

    // Full-size load and read (no address wrap).
    clear_logs();
    cyc_in(1'b1, 1'b0, 9'd256, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 256 * 9; i++) cyc_in(1'b0, 1'b0, 9'd0, 1'b1, 16'($urandom), i == 256 * 9 - 1, 1'b0);
    idle(2);
    chk("big_writes", wr_addr.size(), 256);
    if (wr_addr.size() == 256) chk("big_last_addr", wr_addr[255], 255);
    cyc_in(1'b0, 1'b1, 9'd256, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 258; i++) cyc_in(1'b0, 1'b0, 9'd0, 1'b0, 16'h0, 1'b0, 1'b1);
    idle(2);
    chk("big_reads", kv_idx.size(), 256);
    if (kv_idx.size() == 256) chk("big_last_idx", kv_idx[255], 255);
    chk("big_done", ld_cnt + rd_cnt, 2);

    // Random operations.
    for (int op = 0; op < 60; op++) begin
      int kind;
      logic [8:0] n;
      kind = $urandom_range(0, 2);
      n = ($urandom_range(0, 7) == 0) ? 9'd0 : 9'($urandom_range(1, 6));
      dens = $urandom_range(1, 4);
      cyc_in(kind != 1, kind != 0, n, 1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      b = 0;
      while (m_mode != 0 && b < 400) begin
        w = 16'($urandom);
        cyc_in($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, 9'($urandom),
               $urandom_range(1, dens) == 1, w, $urandom_range(0, 7) == 0,
               $urandom_range(1, dens) == 1);
        if ($urandom_range(0, 299) == 0) do_reset();
        b++;
      end
      n_tests++;
      if (m_mode != 0) begin
        n_fail++;
        $display("FAIL op_budget (op %0d): model still busy after %0d cycles, expected idle", op, b);
        do_reset();
      end
      idle($urandom_range(1, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
